// File: rtl/regfile_write_arbiter_if.sv
// Write-port bus for regfile_write_arbiter: two writeback requesters (A: ALU,
// B: load unit) with valid/ready handshakes, a stall input, the register-file
// write outputs, and status outputs.
interface regfile_write_arbiter_if;
    logic        stall;

    logic        a_valid;
    logic [4:0]  a_addr;
    logic [31:0] a_data;
    logic        a_ready;

    logic        b_valid;
    logic [4:0]  b_addr;
    logic [31:0] b_data;
    logic        b_ready;

    logic [4:0]  write_register;
    logic [31:0] write_data;
    logic        reg_write;

    logic        init_done;
    logic [15:0] write_count;

    // Requester / pipeline side.
    modport master (
        output stall,
        output a_valid, a_addr, a_data,
        input  a_ready,
        output b_valid, b_addr, b_data,
        input  b_ready,
        input  write_register, write_data, reg_write,
        input  init_done, write_count
    );

    // Arbiter side.
    modport slave (
        input  stall,
        input  a_valid, a_addr, a_data,
        output a_ready,
        input  b_valid, b_addr, b_data,
        output b_ready,
        output write_register, write_data, reg_write,
        output init_done, write_count
    );
endinterface

// File: rtl/regfile_write_arbiter.sv
// Sequencer and arbiter for the single write port of a 32x32 register file.
// After reset it sweeps registers 1..31 to zero, then shares the write port
// between two requesters with round-robin priority. Register-file outputs are
// registered; the ready signals are combinational.
module regfile_write_arbiter (
    input  logic                  clk,
    input  logic                  rst,
    regfile_write_arbiter_if.slave bus
);

    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } state_t;

    // Round-robin pointer: which port wins when both are valid.
    typedef enum logic {
        PTR_A = 1'b0,
        PTR_B = 1'b1
    } ptr_t;

    state_t      state;
    state_t      state_next;
    ptr_t        ptr;
    logic [4:0]  cnt;
    logic        a_fire;
    logic        b_fire;

    assign a_fire = bus.a_valid && bus.a_ready;
    assign b_fire = bus.b_valid && bus.b_ready;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples pre-edge values, independent of block evaluation order.
        if (rst) begin
            state <= CLEAR;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode and combinational round-robin grant.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // leaves a signal unassigned and no latch is inferred.
        state_next  = state;
        bus.a_ready = 1'b0;
        bus.b_ready = 1'b0;
        case (state)
            CLEAR: begin
                if (cnt == 5'd31) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                // A wins when it is the only requester or holds the pointer;
                // otherwise B wins if it is requesting.
                if (bus.a_valid && (!bus.b_valid || ptr == PTR_A)) begin
                    bus.a_ready = !bus.stall;
                end else if (bus.b_valid) begin
                    bus.b_ready = !bus.stall;
                end
            end
            default: begin
                state_next = CLEAR;
            end
        endcase
    end

    // Sweep counter, register-file write outputs, pointer and write counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt                <= 5'd1;
            ptr                <= PTR_A;
            bus.write_register <= 5'd0;
            bus.write_data     <= 32'd0;
            bus.reg_write      <= 1'b0;
            bus.init_done      <= 1'b0;
            bus.write_count    <= 16'd0;
        end else if (state == CLEAR) begin
            // Zero one register per edge; stall has no effect during the sweep.
            bus.write_register <= cnt;
            bus.write_data     <= 32'd0;
            bus.reg_write      <= 1'b1;
            cnt                <= cnt + 5'd1;
            if (cnt == 5'd31) begin
                bus.init_done <= 1'b1;
            end
        end else if (a_fire || b_fire) begin
            // Register 0 is accepted and consumed but never issued or counted.
            bus.write_register <= a_fire ? bus.a_addr : bus.b_addr;
            bus.write_data     <= a_fire ? bus.a_data : bus.b_data;
            bus.reg_write      <= (a_fire ? bus.a_addr : bus.b_addr) != 5'd0;
            ptr                <= a_fire ? PTR_B : PTR_A;
            if (((a_fire ? bus.a_addr : bus.b_addr) != 5'd0) &&
                (bus.write_count != 16'hFFFF)) begin
                bus.write_count <= bus.write_count + 16'd1;
            end
        end else begin
            // Idle or stalled: drop the strobe, hold address and data.
            bus.reg_write <= 1'b0;
        end
    end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed bench for regfile_write_arbiter. A small register-file model
// commits the arbiter outputs one edge after they are issued, as the real
// register file does. Inputs change at the falling edge; combinational ready
// is checked just after that, registered outputs 1 ns after the rising edge.
module tb_regfile_write_arbiter;

    logic clk;
    logic rst;
    int   errors;
    int   checks;

    regfile_write_arbiter_if bus ();

    regfile_write_arbiter dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Register-file model, pre-filled with a non-zero pattern so the sweep is visible.
    logic [31:0] mem [32];

    initial begin
        for (int i = 0; i < 32; i++) mem[i] = 32'hDEAD_BEEF;
    end

    // Commit the write presented by the arbiter on the previous edge.
    always @(posedge clk) begin
        if (bus.reg_write && bus.write_register != 5'd0)
            mem[bus.write_register] <= bus.write_data;
    end

    function automatic logic [31:0] rf_read(input logic [4:0] addr);
        return (addr == 5'd0) ? 32'd0 : mem[addr];
    endfunction

    task automatic idle_inputs();
        bus.stall   = 1'b0;
        bus.a_valid = 1'b0;
        bus.a_addr  = 5'd0;
        bus.a_data  = 32'd0;
        bus.b_valid = 1'b0;
        bus.b_addr  = 5'd0;
        bus.b_data  = 32'd0;
    endtask

    // Checks all outputs hold their reset values right now.
    task automatic expect_reset_values(input string tag);
        checks++;
        if (bus.reg_write !== 1'b0 || bus.write_register !== 5'd0 ||
            bus.write_data !== 32'd0 || bus.init_done !== 1'b0 ||
            bus.write_count !== 16'd0) begin
            $display("FAIL %s: rw=%b wr=%0d wd=%0h init=%b wc=%0d, required all 0",
                     tag, bus.reg_write, bus.write_register, bus.write_data,
                     bus.init_done, bus.write_count);
            errors++;
        end
    endtask

    // Runs the 31-edge clear sweep from a just-released reset, with A requesting throughout.
    task automatic run_sweep(input string tag);
        bus.a_valid = 1'b1;
        bus.a_addr  = 5'd9;
        bus.a_data  = 32'h1234;
        for (int k = 1; k <= 31; k++) begin
            @(posedge clk);
            #1;
            checks++;
            if (bus.reg_write !== 1'b1 || bus.write_register !== 5'(k) ||
                bus.write_data !== 32'd0) begin
                $display("FAIL %s sweep edge %0d: rw=%b wr=%0d wd=%0h, required rw=1 wr=%0d wd=0",
                         tag, k, bus.reg_write, bus.write_register, bus.write_data, k);
                errors++;
            end
            checks++;
            if (bus.init_done !== (k == 31)) begin
                $display("FAIL %s init_done edge %0d: got %b, required %b",
                         tag, k, bus.init_done, (k == 31));
                errors++;
            end
            if (k < 31) begin
                checks++;
                if (bus.a_ready !== 1'b0 || bus.b_ready !== 1'b0) begin
                    $display("FAIL %s ready in clear edge %0d: a=%b b=%b, required 0 0",
                             tag, k, bus.a_ready, bus.b_ready);
                    errors++;
                end
            end else begin
                bus.a_valid = 1'b0;
            end
        end
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b1;
        #3;
        expect_reset_values("reset");
        @(negedge clk);
        rst = 1'b0;
        run_sweep("init");
        // Two more idle edges: strobe must be low, counter still zero.
        for (int k = 32; k <= 33; k++) begin
            @(posedge clk);
            #1;
            checks++;
            if (bus.reg_write !== 1'b0 || bus.write_count !== 16'd0) begin
                $display("FAIL idle edge %0d: rw=%b wc=%0d, required rw=0 wc=0",
                         k, bus.reg_write, bus.write_count);
                errors++;
            end
        end
        for (int r = 0; r < 32; r++) begin
            checks++;
            if (rf_read(5'(r)) !== 32'd0) begin
                $display("FAIL cleared r%0d: got %0h, required 0", r, rf_read(5'(r)));
                errors++;
            end
        end
    endtask

    task automatic test_single_write();
        @(negedge clk);
        bus.a_valid = 1'b1;
        bus.a_addr  = 5'd2;
        bus.a_data  = 32'd42;
        #1;
        checks++;
        if (bus.a_ready !== 1'b1 || bus.b_ready !== 1'b0) begin
            $display("FAIL single a_ready: a=%b b=%b, required 1 0", bus.a_ready, bus.b_ready);
            errors++;
        end
        @(posedge clk);
        #1;
        bus.a_valid = 1'b0;
        checks++;
        if (bus.write_register !== 5'd2 || bus.write_data !== 32'd42 ||
            bus.reg_write !== 1'b1 || bus.write_count !== 16'd1) begin
            $display("FAIL single issue: wr=%0d wd=%0d rw=%b wc=%0d, required 2 42 1 1",
                     bus.write_register, bus.write_data, bus.reg_write, bus.write_count);
            errors++;
        end
        @(posedge clk);
        #1;
        checks++;
        if (rf_read(5'd2) !== 32'd42 || bus.reg_write !== 1'b0 ||
            bus.write_register !== 5'd2 || bus.write_data !== 32'd42) begin
            $display("FAIL single commit: r2=%0d rw=%b wr=%0d wd=%0d, required r2=42 rw=0 hold 2/42",
                     rf_read(5'd2), bus.reg_write, bus.write_register, bus.write_data);
            errors++;
        end
    endtask

    // B alone: exercises the B path and returns the pointer to A.
    task automatic test_port_b();
        @(negedge clk);
        bus.b_valid = 1'b1;
        bus.b_addr  = 5'd5;
        bus.b_data  = 32'd3;
        #1;
        checks++;
        if (bus.b_ready !== 1'b1 || bus.a_ready !== 1'b0) begin
            $display("FAIL port_b ready: a=%b b=%b, required 0 1", bus.a_ready, bus.b_ready);
            errors++;
        end
        @(posedge clk);
        #1;
        bus.b_valid = 1'b0;
        checks++;
        if (bus.write_register !== 5'd5 || bus.write_data !== 32'd3 ||
            bus.reg_write !== 1'b1 || bus.write_count !== 16'd2) begin
            $display("FAIL port_b issue: wr=%0d wd=%0d rw=%b wc=%0d, required 5 3 1 2",
                     bus.write_register, bus.write_data, bus.reg_write, bus.write_count);
            errors++;
        end
    endtask

    task automatic test_back_to_back();
        logic exp_a;
        @(negedge clk);
        bus.a_valid = 1'b1;
        bus.a_addr  = 5'd3;
        bus.a_data  = 32'd7;
        bus.b_valid = 1'b1;
        bus.b_addr  = 5'd4;
        bus.b_data  = 32'd9;
        for (int i = 0; i < 4; i++) begin
            exp_a = (i % 2 == 0);
            #1;
            checks++;
            if (bus.a_ready !== exp_a || bus.b_ready !== !exp_a) begin
                $display("FAIL b2b grant %0d: a=%b b=%b, required %b %b",
                         i, bus.a_ready, bus.b_ready, exp_a, !exp_a);
                errors++;
            end
            @(posedge clk);
            #1;
            checks++;
            if (bus.write_register !== (exp_a ? 5'd3 : 5'd4) ||
                bus.write_data !== (exp_a ? 32'd7 : 32'd9) || bus.reg_write !== 1'b1) begin
                $display("FAIL b2b issue %0d: wr=%0d wd=%0d rw=%b, required %0d %0d 1",
                         i, bus.write_register, bus.write_data, bus.reg_write,
                         exp_a ? 3 : 4, exp_a ? 7 : 9);
                errors++;
            end
            @(negedge clk);
        end
        bus.a_valid = 1'b0;
        bus.b_valid = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (rf_read(5'd3) !== 32'd7 || rf_read(5'd4) !== 32'd9 || bus.write_count !== 16'd6) begin
            $display("FAIL b2b commit: r3=%0d r4=%0d wc=%0d, required 7 9 6",
                     rf_read(5'd3), rf_read(5'd4), bus.write_count);
            errors++;
        end
    endtask

    task automatic test_reg_zero();
        @(negedge clk);
        bus.a_valid = 1'b1;
        bus.a_addr  = 5'd0;
        bus.a_data  = 32'd15;
        #1;
        checks++;
        if (bus.a_ready !== 1'b1) begin
            $display("FAIL r0 a_ready: got %b, required 1", bus.a_ready);
            errors++;
        end
        @(posedge clk);
        #1;
        bus.a_valid = 1'b0;
        checks++;
        if (bus.reg_write !== 1'b0 || bus.write_count !== 16'd6 ||
            bus.write_register !== 5'd0 || bus.write_data !== 32'd15) begin
            $display("FAIL r0 issue: rw=%b wc=%0d wr=%0d wd=%0d, required 0 6 0 15",
                     bus.reg_write, bus.write_count, bus.write_register, bus.write_data);
            errors++;
        end
        @(posedge clk);
        #1;
        checks++;
        if (rf_read(5'd0) !== 32'd0) begin
            $display("FAIL r0 read: got %0d, required 0", rf_read(5'd0));
            errors++;
        end
    endtask

    task automatic test_stall();
        @(negedge clk);
        bus.stall   = 1'b1;
        bus.a_valid = 1'b1;
        bus.a_addr  = 5'd7;
        bus.a_data  = 32'd77;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if (bus.a_ready !== 1'b0 || bus.b_ready !== 1'b0) begin
                $display("FAIL stall ready %0d: a=%b b=%b, required 0 0", i, bus.a_ready, bus.b_ready);
                errors++;
            end
            @(posedge clk);
            #1;
            checks++;
            if (bus.reg_write !== 1'b0 || bus.write_count !== 16'd6) begin
                $display("FAIL stall edge %0d: rw=%b wc=%0d, required 0 6", i, bus.reg_write, bus.write_count);
                errors++;
            end
            @(negedge clk);
        end
        bus.stall = 1'b0;
        #1;
        checks++;
        if (bus.a_ready !== 1'b1) begin
            $display("FAIL unstall a_ready: got %b, required 1", bus.a_ready);
            errors++;
        end
        @(posedge clk);
        #1;
        bus.a_valid = 1'b0;
        checks++;
        if (bus.write_register !== 5'd7 || bus.write_data !== 32'd77 ||
            bus.reg_write !== 1'b1 || bus.write_count !== 16'd7) begin
            $display("FAIL unstall issue: wr=%0d wd=%0d rw=%b wc=%0d, required 7 77 1 7",
                     bus.write_register, bus.write_data, bus.reg_write, bus.write_count);
            errors++;
        end
    endtask

    task automatic test_reset_mid_sweep();
        idle_inputs();
        @(negedge clk);
        rst = 1'b1;
        #2;
        @(negedge clk);
        rst = 1'b0;
        for (int k = 1; k <= 10; k++) @(posedge clk);
        #1;
        checks++;
        if (bus.write_register !== 5'd10 || bus.reg_write !== 1'b1) begin
            $display("FAIL mid-sweep edge 10: wr=%0d rw=%b, required 10 1",
                     bus.write_register, bus.reg_write);
            errors++;
        end
        rst = 1'b1;
        #1;
        expect_reset_values("async reset");
        @(negedge clk);
        rst = 1'b0;
        run_sweep("restart");
    endtask

    initial begin
        errors = 0;
        checks = 0;
        test_reset();
        test_single_write();
        test_port_b();
        test_back_to_back();
        test_reg_zero();
        test_stall();
        test_reset_mid_sweep();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
